// File: rtl/iq_capture_buffer.sv
// IQ capture buffer: on arm, stores capture_len I/Q sample pairs into one dual-port RAM,
// then streams them out over a valid/ready handshake. Optional peak |I|+|Q| tracking: IQ_CAPTURE_PEAK_EN.
module iq_capture_buffer #(
  parameter int WIDTH      = 20,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    reset_b,
  input  logic signed [WIDTH-1:0] sig_i,
  input  logic signed [WIDTH-1:0] sig_q,
  input  logic                    arm,
  input  logic                    abort,
  input  logic [DEPTH_LOG2:0]     capture_len,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic signed [WIDTH-1:0] rd_i,
  output logic signed [WIDTH-1:0] rd_q,
  output logic                    rd_last,
  output logic [WIDTH:0]          peak_mag
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_LEN = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_READ,
    S_DONE
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [DEPTH_LOG2-1:0]   rd_addr;
  logic [DEPTH_LOG2-1:0]   last_addr;
  logic [DEPTH_LOG2:0]     len_eff;
  logic                    arm_ok;
  logic                    fire;
  logic                    primed;
  logic [2*WIDTH-1:0]      mem [DEPTH];
  logic [2*WIDTH-1:0]      ram_q;

  assign len_eff = (capture_len > DEPTH_LEN) ? DEPTH_LEN : capture_len;
  assign arm_ok  = (state == S_IDLE) && arm && !abort && (capture_len != '0);
  assign fire    = rd_valid && rd_ready;
  assign rd_last = rd_valid && (rd_ptr == last_addr);
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

  // The RAM address looks one sample ahead on a handshake so the read register
  // refills in the same cycle and back-to-back transfers need no bubble.
  assign rd_addr = fire ? rd_ptr + 1'b1 : rd_ptr;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (arm_ok) state_nxt = S_CAPTURE;
        S_CAPTURE: if (wr_ptr == last_addr) state_nxt = S_READ;
        S_READ:    if (fire && rd_last) state_nxt = S_DONE;
        S_DONE:    state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_addr <= '0;
      primed    <= 1'b0;
      rd_valid  <= 1'b0;
    end else if (abort) begin
      primed   <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arm_ok) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            last_addr <= DEPTH_LOG2'(len_eff - 1'b1);
            primed    <= 1'b0;
          end
        end
        S_CAPTURE: wr_ptr <= wr_ptr + 1'b1;
        S_READ: begin
          // One idle cycle, then the RAM read register holds address 0.
          if (fire) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (rd_last) rd_valid <= 1'b0;
          end else if (!primed) begin
            primed <= 1'b1;
          end else if (!rd_valid) begin
            rd_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the sample memory has no reset so it maps onto block RAM; stale
  // contents are never presented because readout only follows a fresh capture.
  always_ff @(posedge clk) begin
    if (state == S_CAPTURE) mem[wr_ptr] <= {sig_i, sig_q};
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)              ram_q <= '0;
    else if (state == S_READ)  ram_q <= mem[rd_addr];
  end

  assign rd_i = ram_q[2*WIDTH-1:WIDTH];
  assign rd_q = ram_q[WIDTH-1:0];

`ifdef IQ_CAPTURE_PEAK_EN
  logic [WIDTH-1:0] abs_i;
  logic [WIDTH-1:0] abs_q;
  logic [WIDTH:0]   mag;
  logic [WIDTH:0]   peak_r;

  // Negating the most negative value wraps to itself, which read unsigned is
  // exactly its magnitude, so no extra guard bit is needed.
  assign abs_i = sig_i[WIDTH-1] ? $unsigned(-sig_i) : $unsigned(sig_i);
  assign abs_q = sig_q[WIDTH-1] ? $unsigned(-sig_q) : $unsigned(sig_q);
  assign mag   = {1'b0, abs_i} + {1'b0, abs_q};

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)                                         peak_r <= '0;
    else if (arm_ok)                                      peak_r <= '0;
    else if (state == S_CAPTURE && !abort && mag > peak_r) peak_r <= mag;
  end

  assign peak_mag = peak_r;
`else
  assign peak_mag = '0;
`endif

endmodule

// File: doc/iq_capture_buffer.md
IQ_CAPTURE_BUFFER -- requirements
Module: iq_capture_buffer

Interface
REQ-001 Parameter: WIDTH, default 20, bit width of each I/Q input sample.
REQ-002 Parameter: DEPTH_LOG2, default 10, log2 of buffer depth in samples (DEPTH = 2**DEPTH_LOG2).
REQ-003 Port: clk  input  1  clock; all logic on rising edge.
REQ-004 Port: reset_b  input  1  reset, asynchronous, active-low.
REQ-005 Port: sig_i  input  WIDTH  signed in-phase sample, one new sample every clk.
REQ-006 Port: sig_q  input  WIDTH  signed quadrature sample, one new sample every clk.
REQ-007 Port: arm  input  1  single-cycle request to start a capture.
REQ-008 Port: abort  input  1  synchronous cancel of any capture or readout.
REQ-009 Port: capture_len  input  DEPTH_LOG2+1  number of samples to capture, sampled when arm is accepted.
REQ-010 Port: busy  output  1  high in any state other than IDLE.
REQ-011 Port: done  output  1  one-cycle pulse after the last readout handshake.
REQ-012 Port: rd_valid  output  1  readout sample valid.
REQ-013 Port: rd_ready  input  1  consumer accepts the sample when rd_valid and rd_ready are both high.
REQ-014 Port: rd_i  output  WIDTH  readout in-phase sample.
REQ-015 Port: rd_q  output  WIDTH  readout quadrature sample.
REQ-016 Port: rd_last  output  1  high with rd_valid on the final sample of a capture.
REQ-017 Port: peak_mag  output  WIDTH+1  peak of |I|+|Q| seen in the last capture (see Configuration).

Function
REQ-018 FSM states: IDLE, CAPTURE, READ, DONE.
REQ-019 IDLE: arm=1 with capture_len in 1..DEPTH moves to CAPTURE; capture_len=0 ignores arm; capture_len>DEPTH is clamped to DEPTH.
REQ-020 arm outside IDLE is ignored; no capture restarts.
REQ-021 CAPTURE: the first stored sample is the sig_i/sig_q value present on the clock edge after the one on which arm is sampled; one sample is stored per cycle, with no gaps, to addresses 0..len-1.
REQ-022 CAPTURE to READ occurs on the cycle the sample at address len-1 is written.
REQ-023 READ: samples are presented in capture order, starting at address 0. rd_valid rises exactly 2 cycles after the last capture write.
REQ-024 While rd_valid=1 and rd_ready=0, rd_i, rd_q and rd_last hold stable.
REQ-025 With rd_ready held at 1, one sample transfers per cycle with no bubbles.
REQ-026 The handshake of the sample with rd_last=1 moves the FSM to DONE. DONE asserts done for exactly one cycle, then returns to IDLE.
REQ-027 abort=1 returns the FSM to IDLE on the next edge from any state, clears rd_valid, and suppresses done. abort has priority over arm in the same cycle.
REQ-028 rd_i and rd_q are full WIDTH, with no truncation or rounding. Storage is one dual-port RAM of DEPTH x 2*WIDTH.

Reset
REQ-029 While reset_b=0: FSM is in IDLE, and busy, done, rd_valid and rd_last are 0.
REQ-030 While reset_b=0: rd_i, rd_q, peak_mag and all address counters are 0.
REQ-031 Reset asserted mid-capture or mid-readout discards the capture. RAM contents are not cleared and are never read without a new capture.

Configuration
REQ-032 Macro IQ_CAPTURE_PEAK_EN: when defined, peak_mag clears to 0 when arm is accepted.
REQ-033 When defined, during CAPTURE peak_mag updates each cycle to max(peak_mag, |sig_i|+|sig_q|), with the magnitude computed unsigned in WIDTH+1 bits. peak_mag holds its value until the next accepted arm.
REQ-034 When IQ_CAPTURE_PEAK_EN is undefined, peak_mag is tied to 0 and no magnitude logic is synthesized.

Verification
REQ-035 Ramp input (sig_i=n, sig_q=-n), arm with capture_len=8, rd_ready=1 -> rd_i=k0..k0+7 on consecutive cycles, rd_last on the 8th, done 1 cycle later, busy low after that.
REQ-036 capture_len=4, rd_ready toggling 1,0,0,1,... -> exactly 4 handshakes, data held stable during stalls, rd_last only on the 4th.
REQ-037 arm with capture_len=0 -> busy stays 0; arm with capture_len=2000 (DEPTH=1024) -> exactly 1024 samples read out.
REQ-038 abort asserted 3 cycles into CAPTURE, together with arm -> IDLE next cycle, no rd_valid, no done; a later arm captures normally.
REQ-039 reset_b pulsed low during READ -> all outputs 0 immediately (asynchronous reset), busy=0 after release.
REQ-040 With IQ_CAPTURE_PEAK_EN defined, sig_i=-30000 and sig_q=25000 for one captured cycle, all other samples small -> peak_mag=55000; without the macro -> peak_mag=0.
